// File: rtl/op_result_serializer.sv
// Captures one frame of NUM_RES result words and streams them over a valid/ready
// link, one word per transfer, followed by an XOR checksum word; counts completed frames.
module op_result_serializer #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned NUM_RES = 9,
    parameter int unsigned IDX_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_RES*WIDTH-1:0] in_results,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [IDX_W-1:0]         out_index,
    output logic                     out_last,
    output logic [7:0]               frame_count
);

    localparam int unsigned FRAME_W = NUM_RES * WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RES - 1);
    localparam logic [IDX_W-1:0] CHK_IDX  = IDX_W'(NUM_RES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_CHK  = 2'd2
    } state_t;

    state_t             r_state;
    logic [FRAME_W-1:0] r_frame;
    logic [WIDTH-1:0]   r_xor;
    logic [IDX_W-1:0]   r_index;
    logic [WIDTH-1:0]   r_out_data;
    logic               r_out_valid;
    logic               r_out_last;
    logic               r_in_ready;
    logic [7:0]         r_frame_count;

    logic               w_xfer;

    assign w_xfer      = r_out_valid && out_ready;

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_index   = r_index;
    assign out_last    = r_out_last;
    assign frame_count = r_frame_count;

    // The frame is shifted down one word per transfer so the next word is always
    // in the second-lowest slot; out_data holds the word currently on the link.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_frame       <= '0;
            r_xor         <= '0;
            r_index       <= '0;
            r_out_data    <= '0;
            r_out_valid   <= 1'b0;
            r_out_last    <= 1'b0;
            r_in_ready    <= 1'b0;
            r_frame_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (r_in_ready && in_valid) begin
                        r_frame     <= in_results;
                        r_xor       <= '0;
                        r_index     <= '0;
                        r_out_data  <= in_results[WIDTH-1:0];
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b0;
                        r_in_ready  <= 1'b0;
                        r_state     <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    if (w_xfer) begin
                        r_xor   <= r_xor ^ r_out_data;
                        r_frame <= r_frame >> WIDTH;
                        if (r_index == LAST_IDX) begin
                            r_index    <= CHK_IDX;
                            r_out_data <= r_xor ^ r_out_data;
                            r_out_last <= 1'b1;
                            r_state    <= ST_CHK;
                        end else begin
                            r_index    <= r_index + IDX_W'(1);
                            r_out_data <= r_frame[2*WIDTH-1:WIDTH];
                        end
                    end
                end

                ST_CHK: begin
                    if (w_xfer) begin
                        r_out_valid   <= 1'b0;
                        r_out_last    <= 1'b0;
                        r_out_data    <= '0;
                        r_index       <= '0;
                        r_frame_count <= r_frame_count + 8'(1);
                        r_in_ready    <= 1'b1;
                        r_state       <= ST_IDLE;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_in_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_op_result_serializer.sv
// Scoreboard bench for op_result_serializer: stimulus queues expected words,
// a negedge monitor pops and compares each accepted transfer.
module tb_op_result_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [35:0] in_results;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic [3:0]  out_index;
    logic        out_last;
    logic [7:0]  frame_count;

    int          vec = 0;
    int          errs = 0;
    int          cyc = 0;
    int          last_cyc = -1;
    bit          gap_chk = 1'b0;
    logic [8:0]  q[$];

    op_result_serializer #(.WIDTH(4), .NUM_RES(9), .IDX_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_results (in_results),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_last   (out_last),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        vec++;
        errs++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: every accepted word must match the head of the scoreboard.
    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                fail_now($sformatf("unexpected_word idx=%0d data=%0h", out_index, out_data));
            end else begin
                e = q.pop_front();
                chk("word {last,idx,data}", 36'({out_last, out_index, out_data}), 36'(e));
                if (gap_chk && e[7:4] == 4'd0 && last_cyc >= 0)
                    chk("idle_gap_cycles", 36'(cyc - last_cyc), 36'd2);
                if (e[8]) last_cyc = cyc;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready) begin
            @(posedge clk); #1;
            n++;
            if (n > 200) begin
                fail_now("timeout_in_ready");
                return;
            end
        end
    endtask

    task automatic push_expected(input logic [35:0] d);
        logic [3:0] x = 4'd0;
        logic [3:0] w;
        for (int k = 0; k < 9; k++) begin
            w = d[k*4 +: 4];
            x = x ^ w;
            q.push_back({1'b0, 4'(k), w});
        end
        q.push_back({1'b1, 4'd9, x});
    endtask

    task automatic send(input logic [35:0] d, input bit hold);
        wait_ready();
        in_results = d;
        in_valid   = 1'b1;
        push_expected(d);
        @(posedge clk); #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 || out_valid) begin
            @(posedge clk); #1;
            n++;
            if (n > 2000) begin
                fail_now("timeout_drain");
                return;
            end
        end
    endtask

    task automatic wait_index(input logic [3:0] idx);
        int n = 0;
        while (!(out_valid && out_index == idx)) begin
            @(posedge clk); #1;
            n++;
            if (n > 100) begin
                fail_now("timeout_wait_index");
                return;
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_results = '0;
        out_ready  = 1'b1;

        // Reset state
        #2;
        chk("reset_out_valid", 36'(out_valid), 36'd0);
        chk("reset_in_ready", 36'(in_ready), 36'd0);
        chk("reset_frame_count", 36'(frame_count), 36'd0);
        chk("reset_out_regs", 36'({out_last, out_index, out_data}), 36'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_in_ready", 36'(in_ready), 36'd1);

        // T2: plain stream, words 9..1 then checksum 1
        send(36'h123456789, 1'b0);
        chk("first_word_latency", 36'({out_valid, out_index, out_data}), 36'({1'b1, 4'd0, 4'd9}));
        drain();
        chk("frame_count_t2", 36'(frame_count), 36'd1);

        // T3: backpressure at index 4 for 3 cycles
        send(36'h123456789, 1'b0);
        wait_index(4'd4);
        out_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("hold {valid,idx,data}", 36'({out_valid, out_index, out_data}), 36'({1'b1, 4'd4, 4'd5}));
        end
        out_ready = 1'b1;
        drain();
        chk("frame_count_t3", 36'(frame_count), 36'd2);

        // T4: in_valid / in_results activity during SEND is ignored
        send(36'h123456789, 1'b0);
        in_results = 36'hFFFFFFFFF;
        in_valid   = 1'b1;
        repeat (2) @(posedge clk);
        #1 in_valid = 1'b0;
        drain();
        chk("frame_count_t4", 36'(frame_count), 36'd3);

        // T5: all-equal frame, odd count gives checksum C
        send(36'hCCCCCCCCC, 1'b0);
        drain();
        chk("frame_count_t5", 36'(frame_count), 36'd4);

        // T1: reset mid-SEND discards the frame and clears the counter
        send(36'h123456789, 1'b0);
        wait_index(4'd3);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 36'(out_valid), 36'd0);
        chk("midrst_in_ready", 36'(in_ready), 36'd0);
        chk("midrst_frame_count", 36'(frame_count), 36'd0);
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 36'(in_ready), 36'd1);
        chk("post_rst_out_valid", 36'(out_valid), 36'd0);

        // T6: 256 back-to-back frames, counter wraps, one IDLE cycle between frames
        for (int i = 0; i < 256; i++) begin
            send({4'(i), 32'(i) * 32'h9E3779B9}, 1'b1);
            if (i == 1) gap_chk = 1'b1;
            if (i == 255) chk("frame_count_255", 36'(frame_count), 36'd255);
        end
        in_valid = 1'b0;
        drain();
        gap_chk = 1'b0;
        chk("frame_count_wrap", 36'(frame_count), 36'd0);
        chk("scoreboard_empty", 36'(q.size()), 36'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
